// File: rtl/alu_pkg.sv
// Shared ALUop codes, FSM state encoding and op decode helpers for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Slice output select, taken from the low two ALUop bits
  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_SLT_FIX = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_subtracts(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND / OR / full-adder sum with optional B inversion.
// Purely combinational; the sequencer feeds it one operand bit per clock.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       binvert,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       res,
  output logic       cout
);

  logic bb;
  logic sum;

  assign bb   = b ^ binvert;
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (a & cin) | (bb & cin);

  always_comb begin
    res = sum;
    case (op)
      SEL_AND: res = a & bb;
      SEL_OR:  res = a | bb;
      default: res = sum;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: latches operands on start, runs one slice per clock LSB first,
// applies the SLT fix-up and signals completion with ready/busy/done.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       op_q;
  logic             ovf_q, err_q, set_q;

  logic accept;
  logic last_bit;
  logic slice_res, slice_cout;
  logic msb_ovf;

  assign accept   = ready & start;
  assign last_bit = (cnt_q == LAST_BIT);
  assign msb_ovf  = carry_q ^ slice_cout;

  alu_bit_slice u_slice (
    .a       (a_q[cnt_q]),
    .b       (b_q[cnt_q]),
    .binvert (op_subtracts(op_q)),
    .cin     (carry_q),
    .op      (op_q[1:0]),
    .res     (slice_res),
    .cout    (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start)                 state_d = op_supported(op) ? S_RUN : S_DONE;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_RUN: begin
        if (last_bit) state_d = (op_q == OP_SLT) ? S_SLT_FIX : S_DONE;
      end
      S_SLT_FIX: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == S_IDLE) || (state_q == S_DONE);
    busy  = (state_q == S_RUN) || (state_q == S_SLT_FIX);
    done  = (state_q == S_DONE);
  end

  // Result fills from the MSB side so bit i lands at position i after WIDTH shifts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      set_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      cnt_q   <= '0;
      carry_q <= op_subtracts(op);
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= ~op_supported(op);
      set_q   <= 1'b0;
    end else if (state_q == S_RUN) begin
      res_q   <= {slice_res, res_q[WIDTH-1:1]};
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + CW'(1);
      if (last_bit) begin
        set_q <= slice_res ^ msb_ovf;
        if (op_q == OP_ADD || op_q == OP_SUB) ovf_q <= msb_ovf;
      end
    end else if (state_q == S_SLT_FIX) begin
      res_q <= {{(WIDTH-1){1'b0}}, set_q};
      ovf_q <= 1'b0;
    end
  end

  assign result   = res_q;
  assign zero     = (res_q == '0);
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule
